// File: rtl/core_launch_sequencer.sv
// core_launch_sequencer: enables the core clock, waits for it to settle, issues staggered
// per-core start pulses and reports completion or timeout.
module core_launch_sequencer #(
  parameter int NUM_CORES     = 4,
  parameter int WARMUP_CYCLES = 4,
  parameter int STAGGER       = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [NUM_CORES-1:0] core_done,
  output logic                 core_clk_en,
  output logic [NUM_CORES-1:0] core_start,
  output logic                 busy,
  output logic                 all_done,
  output logic                 timeout_err
);
  localparam int WW = $clog2(WARMUP_CYCLES) + 1;
  localparam int SW = $clog2(STAGGER) + 1;
  localparam int IW = $clog2(NUM_CORES) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] W_LAST = WW'(WARMUP_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(STAGGER - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_CORES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, WARMUP, LAUNCH, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [NUM_CORES-1:0] launched, launched_n, mask, mask_n, core_start_n;
  logic start_low_q, rise, busy_n, all_done_n, timeout_n;
  // start_low_q resets to 0, so a start held high through reset cannot relaunch
  assign rise = start & start_low_q;
  always_comb begin
    state_n      = state;
    wcnt_n       = wcnt;
    scnt_n       = scnt;
    idx_n        = idx;
    tcnt_n       = tcnt;
    launched_n   = launched | core_start;
    mask_n       = (state == LAUNCH || state == RUN) ? mask | (core_done & launched) : mask;
    core_start_n = '0;
    all_done_n   = all_done;
    timeout_n    = timeout_err;
    case (state)
      IDLE: if (rise) begin
        state_n = WARMUP;
        wcnt_n  = '0;
      end
      WARMUP: if (wcnt == W_LAST) begin
        state_n      = LAUNCH;
        scnt_n       = '0;
        idx_n        = '0;
        core_start_n = NUM_CORES'(1);
      end else wcnt_n = wcnt + 1'b1;
      LAUNCH: if (idx == I_LAST) begin
        state_n = RUN;
        tcnt_n  = '0;
      end else if (scnt == S_LAST) begin
        idx_n        = idx + 1'b1;
        scnt_n       = '0;
        core_start_n = NUM_CORES'(1) << (idx + 1'b1);
      end else scnt_n = scnt + 1'b1;
      // completion is tested first so it wins over a simultaneous timeout
      RUN: if (&mask) begin
        state_n    = DONE;
        all_done_n = 1'b1;
      end else if (tcnt == T_LAST) begin
        state_n   = DONE;
        timeout_n = 1'b1;
      end else tcnt_n = tcnt + 1'b1;
      DONE: if (!start) begin
        state_n    = IDLE;
        mask_n     = '0;
        launched_n = '0;
        all_done_n = 1'b0;
        timeout_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == WARMUP) || (state_n == LAUNCH) || (state_n == RUN);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wcnt        <= '0;
      scnt        <= '0;
      idx         <= '0;
      tcnt        <= '0;
      launched    <= '0;
      mask        <= '0;
      start_low_q <= 1'b0;
      core_start  <= '0;
      core_clk_en <= 1'b0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      wcnt        <= wcnt_n;
      scnt        <= scnt_n;
      idx         <= idx_n;
      tcnt        <= tcnt_n;
      launched    <= launched_n;
      mask        <= mask_n;
      start_low_q <= ~start;
      core_start  <= core_start_n;
      core_clk_en <= busy_n;
      busy        <= busy_n;
      all_done    <= all_done_n;
      timeout_err <= timeout_n;
    end
  end
endmodule

// File: tb/tb_core_launch_sequencer.sv
// tb_core_launch_sequencer: directed checks of launch timing, done masking, timeout and reset.
module tb_core_launch_sequencer;
  logic clk = 1'b0;
  logic rstn, start;
  logic [3:0] core_done, core_start;
  logic core_clk_en, busy, all_done, timeout_err;
  int checks = 0;
  int fails = 0;
  core_launch_sequencer #(.NUM_CORES(4), .WARMUP_CYCLES(4), .STAGGER(2), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .core_done(core_done),
    .core_clk_en(core_clk_en), .core_start(core_start), .busy(busy),
    .all_done(all_done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // k counts edges after the one that samples the start rise
  function automatic logic [3:0] exp_cs(input int k);
    return k == 4 ? 4'b0001 : k == 6 ? 4'b0010 : k == 8 ? 4'b0100 : k == 10 ? 4'b1000 : 4'b0000;
  endfunction
  // mode 0 nominal, 1 illegal/early done, 2 core 3 silent, 3 core 3 on timeout terminal
  function automatic logic [3:0] dn(input int mode, input int k);
    logic [3:0] d;
    d[0] = (mode == 1) ? (k == 6) : (k >= 9);
    d[1] = k >= 11;
    d[2] = (mode == 1) ? (k == 4) : (k >= 13);
    d[3] = (mode == 0 || mode == 1) ? (k >= 15) : (mode == 3) ? (k >= 25) : 1'b0;
    return d;
  endfunction
  task automatic go(input int mode, input int last_k);
    start = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      chk($sformatf("core_start_m%0d_k%0d", mode, k), core_start, exp_cs(k));
      if (k == 0) begin
        chk($sformatf("busy_start_m%0d", mode), busy, 1);
        chk($sformatf("clk_en_start_m%0d", mode), core_clk_en, 1);
      end
      if (k == 16) begin
        chk($sformatf("busy_k16_m%0d", mode), busy, 1);
        chk($sformatf("all_done_k16_m%0d", mode), all_done, 0);
      end
      if (k == 17) chk($sformatf("all_done_k17_m%0d", mode), all_done, mode == 0);
      if (k == 26) chk($sformatf("busy_k26_m%0d", mode), busy, mode != 0);
      if (k == 27) begin
        chk($sformatf("timeout_k27_m%0d", mode), timeout_err, mode == 1 || mode == 2);
        chk($sformatf("all_done_k27_m%0d", mode), all_done, mode == 0 || mode == 3);
        chk($sformatf("clk_en_k27_m%0d", mode), core_clk_en, 0);
        chk($sformatf("busy_k27_m%0d", mode), busy, 0);
      end
      core_done = dn(mode, k);
    end
  endtask
  task automatic finish_run(input string tag);
    start = 1'b0;
    core_done = 4'b0;
    @(negedge clk);
    chk({tag, "_all_done_clr"}, all_done, 0);
    chk({tag, "_timeout_clr"}, timeout_err, 0);
    chk({tag, "_busy_clr"}, busy, 0);
    chk({tag, "_clk_en_clr"}, core_clk_en, 0);
  endtask
  initial begin
    rstn = 1'b0;
    start = 1'b0;
    core_done = 4'b0;
    repeat (2) @(negedge clk);
    chk("rst_clk_en", core_clk_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_timeout", timeout_err, 0);
    rstn = 1'b1;
    @(negedge clk);
    go(0, 17);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_all_done_%0d", i), all_done, 1);
      chk($sformatf("hold_busy_%0d", i), busy, 0);
      chk($sformatf("hold_core_start_%0d", i), core_start, 0);
    end
    finish_run("nominal");
    go(0, 17);
    finish_run("restart");
    go(1, 27);
    finish_run("early");
    go(2, 27);
    finish_run("timeout");
    go(3, 27);
    finish_run("simul");
    go(0, 6);
    #2 rstn = 1'b0;
    #1;
    chk("async_core_start", core_start, 0);
    chk("async_busy", busy, 0);
    chk("async_clk_en", core_clk_en, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_idle_%0d", i), {busy, core_start}, 0);
    end
    start = 1'b0;
    @(negedge clk);
    go(0, 17);
    finish_run("relaunch");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
